// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: ID-stage register-use fields in, EX forwarding selects and pipeline controls out.
interface hazard_fwd_ctrl_if #(parameter int REG_AW = 5, parameter int SEL_W = 2);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              ex_branch_taken;
    logic              mem_wait;
    logic [SEL_W-1:0]  fwd_a_sel;
    logic [SEL_W-1:0]  fwd_b_sel;
    logic              stall_pc;
    logic              stall_ifid;
    logic              flush_ifid;
    logic              bubble_idex;
    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, ex_branch_taken, mem_wait,
        input  fwd_a_sel, fwd_b_sel, stall_pc, stall_ifid, flush_ifid, bubble_idex
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, ex_branch_taken, mem_wait,
        output fwd_a_sel, fwd_b_sel, stall_pc, stall_ifid, flush_ifid, bubble_idex
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: EX operand forwarding, load-use stall and branch flush for the 5-stage RV32I core.
module hazard_fwd_ctrl #(parameter int REG_AW = 5, parameter int SEL_W = 2) (
    input logic              clk,
    input logic              rst,
    hazard_fwd_ctrl_if.slave bus
);
    logic [REG_AW-1:0] ie_rs1, ie_rs2, ie_rd, em_rd, mw_rd;
    logic              ie_rw, ie_mr, ie_v, em_rw, em_v, mw_rw, mw_v;
    logic              em_ok, mw_ok, load_use, bubble;
    assign em_ok = em_v & em_rw & (em_rd != '0);
    assign mw_ok = mw_v & mw_rw & (mw_rd != '0);
    assign bus.fwd_a_sel = (em_ok && em_rd == ie_rs1) ? SEL_W'(2) : (mw_ok && mw_rd == ie_rs1) ? SEL_W'(1) : '0;
    assign bus.fwd_b_sel = (em_ok && em_rd == ie_rs2) ? SEL_W'(2) : (mw_ok && mw_rd == ie_rs2) ? SEL_W'(1) : '0;
    assign load_use = ie_v & ie_mr & (ie_rd != '0) & bus.id_valid & (ie_rd == bus.id_rs1 | ie_rd == bus.id_rs2);
    // mem_wait freezes everything; a pending flush or load-use re-evaluates once it drops
    assign bubble          = ~bus.mem_wait & (bus.ex_branch_taken | load_use);
    assign bus.bubble_idex = bubble;
    assign bus.flush_ifid  = ~bus.mem_wait & bus.ex_branch_taken;
    assign bus.stall_pc    = bus.mem_wait | (load_use & ~bus.ex_branch_taken);
    assign bus.stall_ifid  = bus.stall_pc;
    // a bubble clears only control; register fields still load so the held consumer sees the load in EX/MEM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {ie_rs1, ie_rs2, ie_rd, ie_rw, ie_mr, ie_v} <= '0;
            {em_rd, em_rw, em_v} <= '0;
            {mw_rd, mw_rw, mw_v} <= '0;
        end else if (!bus.mem_wait) begin
            {mw_rd, mw_rw, mw_v} <= {em_rd, em_rw, em_v};
            {em_rd, em_rw, em_v} <= {ie_rd, ie_rw, ie_v};
            {ie_rs1, ie_rs2, ie_rd} <= {bus.id_rs1, bus.id_rs2, bus.id_rd};
            ie_v  <= bus.id_valid & ~bubble;
            ie_rw <= bus.id_valid & bus.id_regwrite & ~bubble;
            ie_mr <= bus.id_valid & bus.id_memread & ~bubble;
        end
    end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed instruction sequences; expected {fwd_a, fwd_b, stall_pc, stall_ifid, flush, bubble} queued per step.
module tb_hazard_fwd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    hazard_fwd_ctrl_if #(.REG_AW(5), .SEL_W(2)) bus();
    hazard_fwd_ctrl #(.REG_AW(5), .SEL_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [7:0] observed();
        return {bus.fwd_a_sel, bus.fwd_b_sel, bus.stall_pc, bus.stall_ifid, bus.flush_ifid, bus.bubble_idex};
    endfunction

    task automatic check(input string tag);
        logic [7:0] e, o;
        e = exp_q.pop_front();
        o = observed();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, rs2, rd, input logic rw, mr, br, mw);
        bus.id_valid = v;
        bus.id_rs1 = rs1;
        bus.id_rs2 = rs2;
        bus.id_rd = rd;
        bus.id_regwrite = rw;
        bus.id_memread = mr;
        bus.ex_branch_taken = br;
        bus.mem_wait = mw;
    endtask

    task automatic step(input string tag, input logic v, input logic [4:0] rs1, rs2, rd,
                        input logic rw, mr, br, mw, input logic [7:0] e);
        drive(v, rs1, rs2, rd, rw, mr, br, mw);
        exp_q.push_back(e);
        @(negedge clk);
        check(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input string tag, input logic [7:0] e);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, e);
    endtask

    task automatic drain();
        nop("drain1", 8'h00);
        nop("drain2", 8'h00);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        exp_q.push_back(8'h00);
        check("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        // EX/MEM forward to rs1
        step("exmem_add", 1, 1, 2, 5, 1, 0, 0, 0, 8'b00_00_0000);
        step("exmem_sub", 1, 5, 6, 8, 1, 0, 0, 0, 8'b00_00_0000);
        nop("exmem_fwd", 8'b10_00_0000);
        drain();
        // MEM/WB forward to rs2
        step("memwb_add", 1, 1, 2, 5, 1, 0, 0, 0, 8'b00_00_0000);
        step("memwb_unrel", 1, 1, 2, 9, 1, 0, 0, 0, 8'b00_00_0000);
        step("memwb_cons", 1, 3, 5, 10, 1, 0, 0, 0, 8'b00_00_0000);
        nop("memwb_fwd", 8'b00_01_0000);
        drain();
        // both stages match: EX/MEM wins
        step("prio_add1", 1, 1, 2, 5, 1, 0, 0, 0, 8'b00_00_0000);
        step("prio_add2", 1, 1, 2, 5, 1, 0, 0, 0, 8'b00_00_0000);
        step("prio_cons", 1, 5, 5, 11, 1, 0, 0, 0, 8'b00_00_0000);
        nop("prio_fwd", 8'b10_10_0000);
        drain();
        // load-use: one stall, then EX/MEM forward, then MEM/WB forward in real EX
        step("lu_lw", 1, 2, 0, 7, 1, 1, 0, 0, 8'b00_00_0000);
        step("lu_stall", 1, 7, 3, 11, 1, 0, 0, 0, 8'b00_00_1101);
        step("lu_after", 1, 7, 3, 11, 1, 0, 0, 0, 8'b10_00_0000);
        nop("lu_ex", 8'b01_00_0000);
        drain();
        // x0 destination never forwards or stalls
        step("x0_lw", 1, 1, 2, 0, 1, 1, 0, 0, 8'b00_00_0000);
        step("x0_cons", 1, 0, 0, 12, 1, 0, 0, 0, 8'b00_00_0000);
        nop("x0_fwd", 8'b00_00_0000);
        drain();
        // branch flush dominates load-use
        step("br_lw", 1, 1, 2, 7, 1, 1, 0, 0, 8'b00_00_0000);
        step("br_flush", 1, 7, 0, 11, 1, 0, 1, 0, 8'b00_00_0011);
        nop("br_after", 8'b10_00_0000);
        drain();
        // mem_wait freezes a pending load-use for 3 cycles
        step("mw_lw", 1, 1, 2, 7, 1, 1, 0, 0, 8'b00_00_0000);
        for (int i = 0; i < 3; i++)
            step("mw_hold", 1, 7, 3, 11, 1, 0, 0, 1, 8'b00_00_1100);
        step("mw_stall", 1, 7, 3, 11, 1, 0, 0, 0, 8'b00_00_1101);
        step("mw_after", 1, 7, 3, 11, 1, 0, 0, 0, 8'b10_00_0000);
        nop("mw_ex", 8'b01_00_0000);
        drain();
        // asynchronous reset in the middle of a stall
        step("rst_lw", 1, 1, 2, 7, 1, 1, 0, 0, 8'b00_00_0000);
        drive(1, 7, 3, 11, 1, 0, 0, 0);
        exp_q.push_back(8'b00_00_1101);
        @(negedge clk);
        check("rst_stall");
        rst = 1'b1;
        #1;
        exp_q.push_back(8'h00);
        check("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("rst_release", 1, 7, 3, 11, 1, 0, 0, 0, 8'b00_00_0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage RV32I core.
- Keeps a shadow copy of register-use fields for the ID/EX, EX/MEM and MEM/WB stages.
- Drives the 2-bit operand-select inputs of the EX-stage 3:1 forwarding muxes: 2'b10 selects the EX/MEM result, 2'b01 the MEM/WB result, anything else the register-file value.
- Also generates the load-use stall and branch-flush controls for the IF/ID and ID/EX registers.

Parameters:
- REG_AW, 5, register address width
- SEL_W, 2, width of forwarding select (fixed encoding 10/01/00)

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- id_valid  input  1  ID stage holds a real instruction
- id_rs1  input  REG_AW  ID source register 1
- id_rs2  input  REG_AW  ID source register 2
- id_rd  input  REG_AW  ID destination register
- id_regwrite  input  1  ID instruction writes rd
- id_memread  input  1  ID instruction is a load
- ex_branch_taken  input  1  EX resolved branch/jump redirect this cycle
- mem_wait  input  1  data memory not ready; freeze whole pipeline
- fwd_a_sel  output  SEL_W  EX operand A mux select
- fwd_b_sel  output  SEL_W  EX operand B mux select
- stall_pc  output  1  hold PC
- stall_ifid  output  1  hold IF/ID register
- flush_ifid  output  1  clear IF/ID to NOP
- bubble_idex  output  1  load NOP into ID/EX

Behaviour:
- Internal shadow registers:
  - ID/EX: rs1, rs2, rd, regwrite, memread, valid.
  - EX/MEM: rd, regwrite, valid.
  - MEM/WB: rd, regwrite, valid.
- Reset: every shadow valid/regwrite/memread clears to 0 and every rd/rs field to 0, immediately and asynchronously. Consequences:
  - fwd_a_sel = fwd_b_sel = 2'b00.
  - All stall/flush/bubble outputs are 0.
- Advance rule on each rising edge with mem_wait = 0:
  - MEM/WB <= EX/MEM.
  - EX/MEM <= ID/EX.
  - ID/EX <= bubble (all control 0) if bubble_idex, else the ID inputs qualified by id_valid.
- mem_wait = 1: all shadow registers hold. stall_pc = stall_ifid = 1; flush_ifid = bubble_idex = 0.
- Forwarding (combinational from shadows, evaluated for the EX stage), fwd_a_sel:
  - 2'b10 if EX/MEM.valid & EX/MEM.regwrite & EX/MEM.rd != 0 & EX/MEM.rd == ID/EX.rs1.
  - Else 2'b01 if the same condition holds against MEM/WB.
  - Else 2'b00.
  - EX/MEM has priority when both match.
  - fwd_b_sel is identical, using rs2.
  - x0 is never forwarded.
- WB-to-ID hazard: none handled here. The register file is write-first (same-cycle read returns new data).
- Load-use: load_use = ID/EX.valid & ID/EX.memread & ID/EX.rd != 0 & id_valid & (ID/EX.rd == id_rs1 | ID/EX.rd == id_rs2). When asserted:
  - stall_pc = stall_ifid = 1 and bubble_idex = 1.
  - Exactly one bubble per load. Next cycle the load is in EX/MEM and a 2'b10 forward applies.
- Branch flush: ex_branch_taken = 1 gives flush_ifid = 1 and bubble_idex = 1. Flush dominates load_use, so stall_pc = stall_ifid = 0 and the PC takes the redirect.
- Simultaneous mem_wait with branch or load_use: mem_wait dominates. The event is re-evaluated when mem_wait drops, because the shadows are unchanged.
- Outputs are combinational from registered state plus current inputs. Zero-cycle latency within the cycle.
- Reset asserted mid-stall clears the state. Outputs return to the reset values within the same cycle.

Test Plan:
- Reset, then issue add x5 (rd=5) followed by sub using rs1=5 → in the sub's EX cycle fwd_a_sel = 2'b10, fwd_b_sel = 2'b00.
- add x5; unrelated instruction; instruction with rs2=5 → fwd_b_sel = 2'b01 in the consumer's EX cycle.
- add x5; add x5; consumer with rs1=5 → fwd_a_sel = 2'b10 (priority to EX/MEM).
- lw rd=7 then consumer with rs1=7 → one cycle of stall_pc = stall_ifid = bubble_idex = 1, then fwd_a_sel = 2'b10 on the next cycle, with no second stall.
- Writes to rd=0 followed by a consumer with rs1=0 → fwd_a_sel stays 2'b00 and no load-use stall.
- load_use and ex_branch_taken in the same cycle → flush_ifid = 1, bubble_idex = 1, stall_pc = 0.
- Same load_use condition with mem_wait = 1 → bubble_idex = 0, shadows frozen for 3 cycles, then the load-use stall fires once after mem_wait drops.
- rst pulse during a stall → all outputs go to 0 asynchronously.
